// File: rtl/adder_subtractor_pkg.sv
// rtl/adder_subtractor_pkg.sv - operation select encodings and default operand width
package adder_subtractor_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int ADDSUB_N_DEFAULT = 8;

endpackage

// File: rtl/addsub_core.sv
// rtl/addsub_core.sv - combinational N+1-bit add/subtract with carry/borrow in
// Signed-overflow output present only when ADDSUB_OVF_EN is defined.
module addsub_core
  import adder_subtractor_pkg::*;
#(
  parameter int N = ADDSUB_N_DEFAULT
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         C_In,
  input  logic         Add_Sub,
`ifdef ADDSUB_OVF_EN
  output logic         ovf,
`endif
  output logic [N:0]   result
);

  logic [N:0] a_ext;
  logic [N:0] b_ext;
  logic [N:0] c_ext;

  assign a_ext = {1'b0, A};
  assign b_ext = {1'b0, B};
  assign c_ext = {{N{1'b0}}, C_In};

  // Zero-extended operands make bit N the carry on add and the borrow on subtract.
  always_comb begin
    if (Add_Sub == OP_SUB) begin
      result = a_ext - b_ext - c_ext;
    end else begin
      result = a_ext + b_ext + c_ext;
    end
  end

`ifdef ADDSUB_OVF_EN
  logic b_eff_msb;

  assign b_eff_msb = (Add_Sub == OP_SUB) ? ~B[N-1] : B[N-1];
  assign ovf       = (A[N-1] == b_eff_msb) && (result[N-1] != A[N-1]);
`endif

endmodule

// File: rtl/adder_subtractor.sv
// rtl/adder_subtractor.sv - registered add/subtract, one-cycle latency, no backpressure
// Optional ovf output enabled by defining ADDSUB_OVF_EN.
module adder_subtractor
  import adder_subtractor_pkg::*;
#(
  parameter int N = ADDSUB_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         C_In,
  input  logic         Add_Sub,
  input  logic         in_valid,
`ifdef ADDSUB_OVF_EN
  output logic         ovf,
`endif
  output logic [N:0]   Out,
  output logic         out_valid
);

  logic [N:0] core_result;

`ifdef ADDSUB_OVF_EN
  logic core_ovf;
`endif

  addsub_core #(.N(N)) u_core (
    .A       (A),
    .B       (B),
    .C_In    (C_In),
    .Add_Sub (Add_Sub),
`ifdef ADDSUB_OVF_EN
    .ovf     (core_ovf),
`endif
    .result  (core_result)
  );

  // Out (and ovf) hold their last value across idle cycles; only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Out <= core_result;
      end
    end
  end

`ifdef ADDSUB_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= core_ovf;
    end
  end
`endif

endmodule

// File: tb/tb_adder_subtractor.sv
// tb/tb_adder_subtractor.sv - randomized and directed checks against an arithmetic reference model
module tb_adder_subtractor;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         add_sub = 1'b0;
  logic         in_valid = 1'b0;
  logic [N:0]   out;
  logic         out_valid;
`ifdef ADDSUB_OVF_EN
  logic         ovf;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [N:0] m_out = '0;
  logic       m_valid = 1'b0;
  logic       m_ovf = 1'b0;

  always #5 clk = ~clk;

  adder_subtractor #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a),
    .B         (b),
    .C_In      (c_in),
    .Add_Sub   (add_sub),
    .in_valid  (in_valid),
`ifdef ADDSUB_OVF_EN
    .ovf       (ovf),
`endif
    .Out       (out),
    .out_valid (out_valid)
  );

  function automatic logic [N:0] ref_result(int av, int bv, int c, int op);
    int r;
    r = (op == 0) ? (av + bv + c) : (av - bv - c);
    return r[N:0];
  endfunction

  function automatic logic ref_ovf(int av, int bv, int c, int op);
    int sa;
    int sb;
    int r;
    sa = (av >= (1 << (N - 1))) ? av - (1 << N) : av;
    sb = (bv >= (1 << (N - 1))) ? bv - (1 << N) : bv;
    r  = (op == 0) ? (sa + sb + c) : (sa - sb - c);
    return (r > (1 << (N - 1)) - 1) || (r < -(1 << (N - 1)));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out   = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      m_valid = in_valid;
      if (in_valid) begin
        m_out = ref_result(int'(a), int'(b), int'(c_in), int'(add_sub));
        m_ovf = ref_ovf(int'(a), int'(b), int'(c_in), int'(add_sub));
      end
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_out", 64'(out), 64'(m_out));
    check("model_out_valid", 64'(out_valid), 64'(m_valid));
`ifdef ADDSUB_OVF_EN
    check("model_ovf", 64'(ovf), 64'(m_ovf));
`endif
  end

  task automatic drive(input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic cv, input logic op, input logic vld);
    @(negedge clk);
    a        = av;
    b        = bv;
    c_in     = cv;
    add_sub  = op;
    in_valid = vld;
  endtask

  task automatic lit(string name, input logic [N-1:0] av, input logic [N-1:0] bv,
                     input logic cv, input logic op, input logic [N:0] exp);
    drive(av, bv, cv, op, 1'b1);
    @(posedge clk);
    #1;
    check({name, "_out"}, 64'(out), 64'(exp));
    check({name, "_valid"}, 64'(out_valid), 64'd1);
  endtask

  initial begin
    #2;
    check("reset_out", 64'(out), 64'd0);
    check("reset_valid", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    lit("add_carry", 8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF);
    lit("sub_nob", 8'd5, 8'd3, 1'b1, 1'b1, 9'h001);
    lit("sub_bor", 8'd3, 8'd5, 1'b0, 1'b1, 9'h1FE);
    lit("sub_000", 8'd0, 8'd0, 1'b1, 1'b1, 9'h1FF);
    lit("sub_0ff", 8'd0, 8'hFF, 1'b1, 1'b1, 9'h100);
    lit("add_zero", 8'd0, 8'd0, 1'b0, 1'b0, 9'h000);
`ifdef ADDSUB_OVF_EN
    lit("ovf_add", 8'h7F, 8'h01, 1'b0, 1'b0, 9'h080);
    check("ovf_add_flag", 64'(ovf), 64'd1);
    lit("ovf_sub", 8'h80, 8'h01, 1'b0, 1'b1, 9'h07F);
    check("ovf_sub_flag", 64'(ovf), 64'd1);
    lit("noovf_add", 8'h10, 8'h10, 1'b0, 1'b0, 9'h020);
    check("noovf_flag", 64'(ovf), 64'd0);
`endif

    // Idle hold: last result was a known literal, inputs toggle with in_valid low.
    lit("pre_idle", 8'd3, 8'd5, 1'b0, 1'b1, 9'h1FE);
    for (int i = 0; i < 3; i++) begin
      drive(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      @(posedge clk);
      #1;
      check("idle_out", 64'(out), 64'h1FE);
      check("idle_valid", 64'(out_valid), 64'd0);
    end

    for (int i = 0; i < 50; i++) begin
      drive(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end
    for (int i = 0; i < 100; i++) begin
      drive(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
    end

    // Async reset between edges while a result is valid.
    lit("pre_rst", 8'h20, 8'h22, 1'b1, 1'b0, 9'h043);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", 64'(out), 64'd0);
    check("async_rst_valid", 64'(out_valid), 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("resume_out", 64'(out), 64'h043);
    check("resume_valid", 64'(out_valid), 64'd1);

    drive('0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
